placement_stress_array: RTL and testbench

Parametrised placement/routing stress block for timing-closure experiments on the ECP5 flow. It instantiates NUM_REGIONS dense XOR-chain clouds, each tagged for a separate LPF placement group and chained through XING_STAGES-deep crossing pipelines. A start/run controller exercises the array for a fixed cycle count. A rotating signature then proves the logic was not optimised away and gives a bit-exact pass/fail value.

---
 rtl/placement_stress_array.sv | 171 +++++++++++++++++
 tb/tb_placement_stress_array.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/placement_stress_array.sv
// Placement/routing stress array: per-region XOR-chain clouds linked by crossing
// pipelines, driven by a seed/run controller that folds the last tail into a rotating signature.

module placement_cloud #(
  parameter int unsigned WIDTH = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic tail
);

  logic [WIDTH-1:0] chain_q;
  logic [WIDTH-1:0] chain_d;

  // Dense XOR recirculation: every bit mixes with its lower neighbour, bit 0 with the tail.
  always_comb begin
    chain_d = chain_q;
    if (clr) begin
      chain_d = '0;
    end else if (en) begin
      chain_d[0]         = din ^ chain_q[WIDTH-1];
      chain_d[WIDTH-1:1] = chain_q[WIDTH-2:0] ^ chain_q[WIDTH-1:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= chain_d;
  end

  assign tail = chain_q[WIDTH-1];

endmodule

module placement_stress_array #(
  parameter int unsigned NUM_REGIONS = 2,
  parameter int unsigned WIDTH       = 2000,
  parameter int unsigned XING_STAGES = 1,
  parameter int unsigned RUN_CYCLES  = 1024,
  parameter int unsigned SIG_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature,
  output logic                 led
);

  localparam int unsigned CNT_W = $clog2(RUN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cloud_en;
  logic                 cloud_clr;
  logic [NUM_REGIONS-1:0] tail;
  logic [NUM_REGIONS-1:0] cin;

  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_region
    if (k == 0) begin : g_src
      assign cin[k] = 1'b1;
    end else begin : g_xing
      // Ungrouped link registers so the router has to bridge the two regions.
      logic [XING_STAGES-1:0] xing_q;
      logic [XING_STAGES-1:0] xing_d;

      always_comb begin
        xing_d = xing_q;
        if (cloud_clr) begin
          xing_d = '0;
        end else if (cloud_en) begin
          xing_d[0] = tail[k-1];
          for (int j = 1; j < int'(XING_STAGES); j++) xing_d[j] = xing_q[j-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) xing_q <= '0;
        else     xing_q <= xing_d;
      end

      assign cin[k] = xing_q[XING_STAGES-1];
    end

    if (k < 10) begin : g_cloud
      (* UGROUP = {"region_", 8'(48 + k)} *)
      placement_cloud #(.WIDTH(WIDTH)) u_cloud (
        .clk  (clk),
        .rst  (rst),
        .clr  (cloud_clr),
        .en   (cloud_en),
        .din  (cin[k]),
        .tail (tail[k])
      );
    end else begin : g_cloud
      (* UGROUP = {"region_", 8'(48 + k / 10), 8'(48 + k % 10)} *)
      placement_cloud #(.WIDTH(WIDTH)) u_cloud (
        .clk  (clk),
        .rst  (rst),
        .clr  (cloud_clr),
        .en   (cloud_en),
        .din  (cin[k]),
        .tail (tail[k])
      );
    end
  end

  // Controller next state; status flags are decoded from the next state so they register in step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    cloud_en  = 1'b0;
    cloud_clr = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_SEED;
      ST_SEED: begin
        cloud_clr = 1'b1;
        cnt_d     = '0;
        sig_d     = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        cloud_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        sig_d    = {sig_q[SIG_WIDTH-2:0], sig_q[SIG_WIDTH-1]} ^ SIG_WIDTH'(tail[NUM_REGIONS-1]);
        if (cnt_q == CNT_W'(RUN_CYCLES - 1)) state_d = ST_DONE;
      end
      ST_DONE: if (start) state_d = ST_SEED;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SEED) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;
  assign led       = tail[NUM_REGIONS-1];

endmodule

// File: tb/tb_placement_stress_array.sv
// Bench for placement_stress_array: a small single-region instance and a three-region
// instance, both checked cycle by cycle against an array/queue model of the chain rules.

module tb_placement_stress_array;

  localparam int MAXR = 4;
  localparam int MAXW = 8;
  localparam int MAXC = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, busy_a, done_a, led_a;
  logic [7:0] sig_a;
  logic        rst_b, start_b, busy_b, done_b, led_b;
  logic [31:0] sig_b;

  placement_stress_array #(
    .NUM_REGIONS(1), .WIDTH(2), .XING_STAGES(1), .RUN_CYCLES(6), .SIG_WIDTH(8)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .signature(sig_a), .led(led_a)
  );

  placement_stress_array #(
    .NUM_REGIONS(3), .WIDTH(4), .XING_STAGES(2), .RUN_CYCLES(64), .SIG_WIDTH(32)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .signature(sig_b), .led(led_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  longint unsigned m_sig [0:MAXC];
  bit              m_led [0:MAXC];
  int              m_chain [0:MAXC][0:MAXR-1];

  logic [63:0] idle_sig  [2];
  logic        idle_done [2];
  logic        idle_led  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: step every cloud and link from the chain rules, recording the state after each RUN cycle.
  task automatic build_model(input int nr, input int w, input int xs, input int rc, input int sw);
    bit ch [MAXR][MAXW];
    bit nx [MAXR][MAXW];
    int pipe [MAXR][$];
    longint unsigned sig, mask;
    bit tl, din;
    mask = (sw >= 64) ? '1 : ((64'd1 << sw) - 64'd1);
    for (int r = 0; r < MAXR; r++) begin
      for (int i = 0; i < MAXW; i++) ch[r][i] = 1'b0;
      pipe[r].delete();
      if (r >= 1) for (int s = 0; s < xs; s++) pipe[r].push_front(0);
    end
    sig = 0;
    m_sig[0] = 0;
    m_led[0] = 1'b0;
    for (int r = 0; r < MAXR; r++) m_chain[0][r] = 0;
    for (int c = 1; c <= rc; c++) begin
      tl  = ch[nr-1][w-1];
      sig = ((((sig << 1) | (sig >> (sw - 1))) & mask) ^ longint'(tl));
      for (int r = 0; r < nr; r++) begin
        din = (r == 0) ? 1'b1 : bit'(pipe[r][$]);
        nx[r][0] = din ^ ch[r][w-1];
        for (int i = 1; i < w; i++) nx[r][i] = ch[r][i-1] ^ ch[r][i];
      end
      for (int r = 1; r < nr; r++) begin
        void'(pipe[r].pop_back());
        pipe[r].push_front(int'(ch[r-1][w-1]));
      end
      for (int r = 0; r < nr; r++) begin
        m_chain[c][r] = 0;
        for (int i = 0; i < w; i++) begin
          ch[r][i] = nx[r][i];
          if (nx[r][i]) m_chain[c][r] += (1 << i);
        end
      end
      m_sig[c] = sig;
      m_led[c] = ch[nr-1][w-1];
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask

  task automatic set_rst(input int sel, input logic v);
    if (sel == 0) rst_a = v;
    else          rst_b = v;
  endtask

  task automatic check_out(input int sel, input string tag, input logic b, input logic d,
                           input logic [63:0] s, input logic l);
    if (sel == 0) begin
      check({tag, "_busy"}, 64'(busy_a), 64'(b));
      check({tag, "_done"}, 64'(done_a), 64'(d));
      check({tag, "_sig"},  64'(sig_a),  s);
      check({tag, "_led"},  64'(led_a),  64'(l));
    end else begin
      check({tag, "_busy"}, 64'(busy_b), 64'(b));
      check({tag, "_done"}, 64'(done_b), 64'(d));
      check({tag, "_sig"},  64'(sig_b),  s);
      check({tag, "_led"},  64'(led_b),  64'(l));
    end
  endtask

  task automatic check_chains(input int j);
    logic [3:0] c0, c1, c2;
    c0 = dut_b.g_region[0].g_cloud.u_cloud.chain_q;
    c1 = dut_b.g_region[1].g_cloud.u_cloud.chain_q;
    c2 = dut_b.g_region[2].g_cloud.u_cloud.chain_q;
    check($sformatf("b_chain0_j%0d", j), 64'(c0), 64'(m_chain[j][0]));
    check($sformatf("b_chain1_j%0d", j), 64'(c1), 64'(m_chain[j][1]));
    check($sformatf("b_chain2_j%0d", j), 64'(c2), 64'(m_chain[j][2]));
    if (j <= 3) check($sformatf("b_c1_quiet_j%0d", j), 64'(c1), 64'd0);
    if (j <= 6) check($sformatf("b_c2_quiet_j%0d", j), 64'(c2), 64'd0);
  endtask

  // One start pulse after `gap` idle cycles; optional ignored start at RUN offset inj, optional rst at rst_at.
  task automatic do_run(input int sel, input int rc, input int gap, input int inj, input int rst_at);
    string p;
    p = (sel == 0) ? "a" : "b";
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      check_out(sel, $sformatf("%s_idle", p), 1'b0, idle_done[sel], idle_sig[sel], idle_led[sel]);
    end
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    check_out(sel, $sformatf("%s_seed", p), 1'b1, 1'b0, idle_sig[sel], idle_led[sel]);
    for (int j = 0; j <= rc; j++) begin
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      if (j > 0 && j - 1 == rst_at) begin
        set_rst(sel, 1'b0);
        check_out(sel, $sformatf("%s_rst", p), 1'b0, 1'b0, 64'd0, 1'b0);
        if (sel == 1) check_chains(0);
        idle_done[sel] = 1'b0;
        idle_sig[sel]  = '0;
        idle_led[sel]  = 1'b0;
        return;
      end
      check_out(sel, $sformatf("%s_run_j%0d", p, j), (j < rc), (j == rc), 64'(m_sig[j]), m_led[j]);
      if (sel == 1) check_chains(j);
      if (sel == 0 && j == rc) check("a_final_0x09", 64'(sig_a), 64'h09);
      if (j == inj) set_start(sel, 1'b1);
      if (j == rst_at) set_rst(sel, 1'b1);
    end
    idle_done[sel] = 1'b1;
    idle_sig[sel]  = 64'(m_sig[rc]);
    idle_led[sel]  = m_led[rc];
  endtask

  initial begin
    int gap, inj, rat;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    for (int s = 0; s < 2; s++) begin
      idle_done[s] = 1'b0;
      idle_sig[s]  = '0;
      idle_led[s]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_out(0, "a_reset", 1'b0, 1'b0, 64'd0, 1'b0);
      check_out(1, "b_reset", 1'b0, 1'b0, 64'd0, 1'b0);
    end

    build_model(1, 2, 1, 6, 8);
    do_run(0, 6, 2, -1, -1);
    do_run(0, 6, 0, -1, -1);
    do_run(0, 6, 1, 2, -1);
    do_run(0, 6, 1, -1, 3);
    do_run(0, 6, 3, -1, -1);
    for (int n = 0; n < 3; n++) begin
      gap = int'($urandom_range(0, 3));
      inj = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 5)) : -1;
      do_run(0, 6, gap, inj, -1);
    end

    build_model(3, 4, 2, 64, 32);
    do_run(1, 64, 1, -1, -1);
    for (int n = 0; n < 6; n++) begin
      gap = int'($urandom_range(0, 4));
      inj = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 63)) : -1;
      rat = (n < 5 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 63)) : -1;
      do_run(1, 64, gap, inj, rat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
